// File: rtl/uart_tx_param_if.sv
// Write-side handshake for uart_tx_param.
// The producer drives wr_valid/wr_data. The transmitter returns wr_ready (FIFO not full).
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a small write FIFO.
//
// Features:
// - Runtime baud divisor (0 and 1 are treated as 2).
// - 5..DATA_W data bits, sent LSB first.
// - None/even/odd parity, and 1 or 2 stop bits.
// - Frames go out back-to-back while the FIFO holds data.
//
// The configuration is latched when each frame is popped from the FIFO.
//
// Optional feature, macro UART_TX_BREAK_EN:
// - Adds the tx_break input and a BREAK state.
// - The line is held low while tx_break is high.
// - Afterwards the line is held high for one bit period, then the block returns to idle.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [3:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                        tx_break,
`endif
  uart_tx_param_if.slave              wr_if,
  output logic                        tx_serial,
  output logic                        tx_active,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MAX_BITS = 4'(DATA_W);
  localparam logic [3:0] MIN_BITS = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // - The head entry is read combinationally, so a pop and the frame latch
  //   happen on the same edge.
  // - Reset only clears the pointers and the count. Stale memory contents are
  //   unreachable after that.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign push         = wr_if.wr_valid && !fifo_full;
  assign head_data    = mem_q[rd_ptr_q];
  assign wr_if.wr_ready = !fifo_full;
  assign fifo_count   = count_q;

  // FIFO storage: write port only, no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_if.wr_data;
    end
  end

  // FIFO pointer/occupancy next-state.
  // - A push and a pop in the same cycle cancel out in the count.
  // - The pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // ---------------------------------------------------------------------------
  // Configuration fix-ups applied at frame latch time
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_fix;
  logic [3:0]       nbits_fix;
  logic             par_en_fix;
  logic             par_odd_fix;

  // Clamp the divisor and the bit count, and decode the parity mode.
  always_comb begin
    div_fix = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    if (cfg_data_bits < MIN_BITS) begin
      nbits_fix = MIN_BITS;
    end else if (cfg_data_bits > MAX_BITS) begin
      nbits_fix = MAX_BITS;
    end else begin
      nbits_fix = cfg_data_bits;
    end
    par_en_fix  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    par_odd_fix = (cfg_parity == 2'b10);
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM and datapath
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              stop2_q, stop2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic              par_acc_q, par_acc_d;
  logic              tx_q, tx_d;
  logic              active_q, active_d;
  logic              bit_end;
  logic              frame_edge;
`ifdef UART_TX_BREAK_EN
  logic              brk_rel_q, brk_rel_d;
`endif

  assign bit_end   = (cnt_q == div_q - 1'b1);
  assign tx_serial = tx_q;
  assign tx_active = active_q;
  // Decoded from registered state: high exactly in the last cycle of the stop period.
  assign tx_done   = (state_q == ST_STOP) && bit_end && (!stop2_q || (idx_q == 4'd1));

  // Next-state and output logic.
  // - The tx bit for the next period is chosen at each bit boundary, so the
  //   line output is registered.
  // - frame_edge marks a frame boundary, where the next frame (or a break) is chosen.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    idx_d      = idx_q;
    par_acc_d  = par_acc_q;
    tx_d       = tx_q;
    active_d   = active_q;
    pop        = 1'b0;
    frame_edge = 1'b0;
    cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
`ifdef UART_TX_BREAK_EN
    brk_rel_d  = brk_rel_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        frame_edge = 1'b1;
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 4'd0;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          par_acc_d = par_acc_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          if (idx_q == nbits_q - 4'd1) begin
            idx_d = 4'd0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_acc_q ^ shift_q[0] ^ par_odd_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            tx_d  = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = 4'd0;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && (idx_q == 4'd0)) begin
            idx_d = 4'd1;
          end else begin
            frame_edge = 1'b1;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!brk_rel_q) begin
          // Hold the line low. Start the recovery bit once tx_break drops.
          cnt_d = '0;
          if (!tx_break) begin
            brk_rel_d = 1'b1;
            tx_d      = 1'b1;
          end
        end else if (bit_end) begin
          state_d   = ST_IDLE;
          active_d  = 1'b0;
          brk_rel_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d  = ST_IDLE;
        tx_d     = 1'b1;
        active_d = 1'b0;
      end
    endcase

    // Frame boundary handling.
    // - Break takes priority over a FIFO pop.
    // - Otherwise the next queued frame starts without an idle bit.
    if (frame_edge) begin
`ifdef UART_TX_BREAK_EN
      if (tx_break) begin
        state_d   = ST_BREAK;
        tx_d      = 1'b0;
        active_d  = 1'b1;
        brk_rel_d = 1'b0;
        div_d     = div_fix;
        cnt_d     = '0;
      end else
`endif
      if (!fifo_empty) begin
        pop       = 1'b1;
        state_d   = ST_START;
        shift_d   = head_data;
        nbits_d   = nbits_fix;
        par_en_d  = par_en_fix;
        par_odd_d = par_odd_fix;
        stop2_d   = cfg_stop2;
        div_d     = div_fix;
        cnt_d     = '0;
        idx_d     = 4'd0;
        par_acc_d = 1'b0;
        tx_d      = 1'b0;
        active_d  = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        tx_d     = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  // State register.
  // - Reset aborts any frame immediately and flushes the FIFO.
  // - The line returns high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      nbits_q   <= MIN_BITS;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      div_q     <= DIV_W'(2);
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      par_acc_q <= 1'b0;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_BREAK_EN
      brk_rel_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      par_acc_q <= par_acc_d;
      tx_q      <= tx_d;
      active_q  <= active_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_BREAK_EN
      brk_rel_q <= brk_rel_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param.
// - A line-level reference model expands each popped byte into a per-clock
//   waveform queue, built from the frame format rules.
// - Every clock, the DUT outputs are compared against that queue.
// - Directed scenarios are followed by a randomized phase.
module tb_uart_tx_param;
  localparam int DATA_W     = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [DIV_W-1:0]  baud_div;
  logic [3:0]        cfg_data_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              tx_serial;
  logic              tx_active;
  logic              tx_done;
  logic [CNT_W-1:0]  fifo_count;
`ifdef UART_TX_BREAK_EN
  logic              tx_break;
`endif

  uart_tx_param_if #(.DATA_W(DATA_W)) wr_if ();

  uart_tx_param #(
    .DATA_W(DATA_W),
    .DIV_W(DIV_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .baud_div(baud_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break),
`endif
    .wr_if(wr_if.slave),
    .tx_serial(tx_serial),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                line_q[$];
  bit                done_q[$];
  logic [DATA_W-1:0] fifo_m[$];
  bit                exp_tx   = 1'b1;
  bit                exp_act  = 1'b0;
  bit                exp_done = 1'b0;

  // Expand one byte into its per-clock line samples, using the configuration
  // currently on the inputs.
  task automatic build_frame(input logic [DATA_W-1:0] d);
    int  div, n, s;
    bit  pen, podd, p;
    bit  bits[$];
    div  = (baud_div < 2) ? 2 : int'(baud_div);
    n    = (cfg_data_bits < 5) ? 5 : ((cfg_data_bits > DATA_W) ? DATA_W : int'(cfg_data_bits));
    pen  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    podd = (cfg_parity == 2'b10);
    s    = cfg_stop2 ? 2 : 1;
    p    = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (pen) bits.push_back(p ^ podd);
    for (int i = 0; i < s; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < div; c++) begin
        line_q.push_back(bits[b]);
        done_q.push_back((b == bits.size() - 1) && (c == div - 1));
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    bit can_push;
    if (reset) begin
      line_q.delete();
      done_q.delete();
      fifo_m.delete();
      exp_tx   = 1'b1;
      exp_act  = 1'b0;
      exp_done = 1'b0;
    end else begin
      can_push = (fifo_m.size() < FIFO_DEPTH);
      if (line_q.size() == 0 && fifo_m.size() > 0) build_frame(fifo_m.pop_front());
      if (wr_if.wr_valid && can_push) fifo_m.push_back(wr_if.wr_data);
      if (line_q.size() > 0) begin
        exp_tx   = line_q.pop_front();
        exp_done = done_q.pop_front();
        exp_act  = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_done = 1'b0;
        exp_act  = 1'b0;
      end
    end
  end

  // ---------------- per-cycle checking ----------------
  bit check_en    = 1'b0;
  int act_cycles  = 0;
  int done_cnt    = 0;
  int frame_no    = 0;

  always @(negedge clock) begin
    if (check_en) begin
      check_eq("tx_serial",  tx_serial,  exp_tx);
      check_eq("tx_active",  tx_active,  exp_act);
      check_eq("tx_done",    tx_done,    exp_done);
      check_eq("fifo_count", fifo_count, fifo_m.size());
      check_eq("wr_ready",   wr_if.wr_ready, fifo_m.size() < FIFO_DEPTH);
    end
    if (tx_active) act_cycles++;
    if (tx_done) begin
      done_cnt++;
      frame_no++;
      $display("[TB] frame %0d done at t=%0t", frame_no, $time);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DATA_W-1:0] d);
    int g;
    g = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    while (!wr_if.wr_ready && g < 2000) begin
      @(negedge clock);
      g++;
    end
    check_eq("send_timeout", g < 2000, 1);
    @(negedge clock);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((tx_active || fifo_count != 0 || line_q.size() != 0 || fifo_m.size() != 0) && g < 20000) begin
      @(negedge clock);
      g++;
    end
    check_eq("idle_timeout", g < 20000, 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic set_cfg(input int div, input int nb, input int par, input bit st2);
    baud_div      = DIV_W'(div);
    cfg_data_bits = 4'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = st2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
`ifdef UART_TX_BREAK_EN
    tx_break = 1'b0;
`endif
    set_cfg(4, 8, 0, 1'b0);
    repeat (3) @(negedge clock);
    check_eq("rst_tx",     tx_serial,  1);
    check_eq("rst_active", tx_active,  0);
    check_eq("rst_done",   tx_done,    0);
    check_eq("rst_ready",  wr_if.wr_ready, 1);
    check_eq("rst_count",  fifo_count, 0);
    reset = 1'b0;
    @(negedge clock);
    check_en = 1'b1;

    // 1: 8N1 at 4 clocks/bit
    act_cycles = 0; done_cnt = 0;
    send(8'hA5);
    wait_idle();
    check_eq("t1_active_cycles", act_cycles, 40);
    check_eq("t1_done_pulses",   done_cnt,   1);

    // 2: 7 bits, even then odd parity, then bit 7 ignored
    set_cfg(3, 7, 1, 1'b0);
    act_cycles = 0;
    send(8'h53);
    wait_idle();
    check_eq("t2_even_cycles", act_cycles, 30);
    set_cfg(3, 7, 2, 1'b0);
    send(8'h53);
    wait_idle();
    send(8'hD3);
    wait_idle();

    // 3: burst of six writes with valid held high
    set_cfg(4, 8, 0, 1'b0);
    act_cycles = 0; done_cnt = 0;
    for (int i = 1; i <= 6; i++) send(DATA_W'(i));
    wait_idle();
    check_eq("t3_active_cycles", act_cycles, 6 * 40);
    check_eq("t3_done_pulses",   done_cnt,   6);

    // 4: config change mid-frame applies only to the queued frame
    act_cycles = 0;
    send(8'h5A);
    send(8'hC3);
    repeat (12) @(negedge clock);
    set_cfg(8, 8, 0, 1'b1);
    wait_idle();
    check_eq("t4_active_cycles", act_cycles, 40 + 8 * 11);

    // 5: reset in the middle of a frame with entries queued
    set_cfg(4, 8, 0, 1'b0);
    done_cnt = 0;
    send(8'hFF);
    send(8'h11);
    send(8'h22);
    repeat (17) @(negedge clock);
    check_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("t5_tx_async",  tx_serial,  1);
    check_eq("t5_active",    tx_active,  0);
    check_eq("t5_count",     fifo_count, 0);
    check_eq("t5_done",      tx_done,    0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_en = 1'b1;
    check_eq("t5_no_done", done_cnt, 0);
    send(8'h3C);
    wait_idle();

    // 6: divisors 0 and 1 behave as 2
    set_cfg(0, 8, 0, 1'b0);
    act_cycles = 0;
    send(8'h96);
    wait_idle();
    check_eq("t6_div0_cycles", act_cycles, 20);
    set_cfg(1, 8, 0, 1'b0);
    act_cycles = 0;
    send(8'h69);
    wait_idle();
    check_eq("t6_div1_cycles", act_cycles, 20);

    // Randomized traffic with occasional configuration changes
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      wr_if.wr_valid = ($urandom_range(0, 3) == 0);
      wr_if.wr_data  = DATA_W'($urandom);
      if ($urandom_range(0, 39) == 0)
        set_cfg($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
    end
    wr_if.wr_valid = 1'b0;
    wait_idle();

`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame: the frame completes first, then the line is held low
    begin
      int g;
      set_cfg(2, 8, 0, 1'b0);
      send(8'h55);
      repeat (3) @(negedge clock);
      tx_break = 1'b1;
      g = 0;
      while (!tx_done && g < 500) begin
        @(negedge clock);
        g++;
      end
      check_eq("brk_frame_done", g < 500, 1);
      check_en = 1'b0;
      @(negedge clock);
      check_eq("brk_low",    tx_serial, 0);
      check_eq("brk_active", tx_active, 1);
      repeat (8) @(negedge clock);
      check_eq("brk_hold_low", tx_serial, 0);
      tx_break = 1'b0;
      @(negedge clock);
      check_eq("brk_rel_tx0",  tx_serial, 1);
      check_eq("brk_rel_act0", tx_active, 1);
      @(negedge clock);
      check_eq("brk_rel_tx1",  tx_serial, 1);
      check_eq("brk_rel_act1", tx_active, 1);
      @(negedge clock);
      check_eq("brk_idle_act", tx_active, 0);
      check_eq("brk_idle_tx",  tx_serial, 1);
      check_en = 1'b1;
    end
`endif

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
